// File: rtl/dmem_lsu.sv
// Load/store unit bridging the memory stage to a word-only data memory.
// Latency: load result and err one cycle after accept; a store occupies IDLE + WRITE (2 cycles).
// Backpressure: req_ready is low only during WRITE; the requester holds its request until accepted.
//
// Ports:
//   clk, rstn                       clock (rising edge), async active-low reset
//   req_valid/req_ready             request handshake; req_we, req_funct3, req_addr, req_wdata, req_pc
//   load_valid, load_data           one-cycle pulse with the extended load result (held between loads)
//   err                             one-cycle pulse for a misaligned or illegal request
//   mem_we, mem_a, mem_wd, mem_pc   word write port to dmem; mem_rd is dmem's combinational read data
module dmem_lsu #(
    parameter int XLEN      = 32,
    parameter int ADDR_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    input  logic [ADDR_SIZE-1:0] req_pc,
    output logic                 req_ready,
    output logic                 load_valid,
    output logic [XLEN-1:0]      load_data,
    output logic                 err,
    output logic                 mem_we,
    output logic [XLEN-1:0]      mem_a,
    output logic [XLEN-1:0]      mem_wd,
    output logic [ADDR_SIZE-1:0] mem_pc,
    input  logic [XLEN-1:0]      mem_rd
);

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t                 r_state;
    logic [XLEN-1:0]        r_wdata;
    logic [ADDR_SIZE-1:0]   r_addr;
    logic [ADDR_SIZE-1:0]   r_pc;

    logic [ADDR_SIZE-1:0]   w_aligned;
    logic                   w_illegal;
    logic                   w_misalign;
    logic [7:0]             w_byte;
    logic [15:0]            w_half;
    logic [XLEN-1:0]        w_load_ext;
    logic [XLEN-1:0]        w_merged;
    logic                   w_idle;

    assign w_idle    = (r_state == S_IDLE);
    assign w_aligned = {req_addr[ADDR_SIZE-1:2], 2'b00};

    // Everything memory-facing is a pure function of the state register, so
    // an async reset during WRITE drops mem_we without waiting for a clock.
    assign req_ready = w_idle;
    assign mem_we    = (r_state == S_WRITE);
    assign mem_a     = w_idle ? XLEN'(w_aligned) : XLEN'(r_addr);
    assign mem_pc    = w_idle ? req_pc : r_pc;
    assign mem_wd    = w_idle ? '0 : r_wdata;

    // Legality: unknown funct3 or unsigned-store encodings are illegal;
    // halfwords must be 2-byte aligned, words 4-byte aligned.
    always_comb begin
        w_illegal  = 1'b0;
        w_misalign = 1'b0;
        case (req_funct3)
            3'b000: w_misalign = 1'b0;
            3'b001: w_misalign = req_addr[0];
            3'b010: w_misalign = |req_addr[1:0];
            3'b100: w_illegal  = req_we;
            3'b101: begin
                w_illegal  = req_we;
                w_misalign = req_addr[0];
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Lane extraction from the aligned read word.
    assign w_byte = mem_rd[{req_addr[1:0], 3'b000} +: 8];
    assign w_half = mem_rd[{req_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load_ext = mem_rd;
        case (req_funct3)
            3'b000:  w_load_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_load_ext = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_load_ext = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_ext = mem_rd;
        endcase
    end

    // Read-merge: splice the store data into the current word so the
    // memory only ever sees full-word writes.
    always_comb begin
        w_merged = mem_rd;
        case (req_funct3[1:0])
            2'b00:   w_merged[{req_addr[1:0], 3'b000} +: 8]  = req_wdata[7:0];
            2'b01:   w_merged[{req_addr[1], 4'b0000} +: 16]  = req_wdata[15:0];
            default: w_merged = req_wdata;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_wdata    <= '0;
            r_addr     <= '0;
            r_pc       <= '0;
            load_valid <= 1'b0;
            load_data  <= '0;
            err        <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            err        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (w_illegal || w_misalign) begin
                            err <= 1'b1;
                        end else if (req_we) begin
                            r_wdata <= w_merged;
                            r_addr  <= w_aligned;
                            r_pc    <= req_pc;
                            r_state <= S_WRITE;
                        end else begin
                            load_valid <= 1'b1;
                            load_data  <= w_load_ext;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

    localparam int K_LOAD  = 0;
    localparam int K_ERR   = 1;
    localparam int K_STORE = 2;

    typedef struct {
        int          kind;
        logic [31:0] d;
        logic [31:0] a;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, req_pc;
    logic        req_ready, load_valid, err, mem_we;
    logic [31:0] load_data, mem_a, mem_wd, mem_pc, mem_rd;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    // Bench-side word memory with preload port (single writer process).
    logic [31:0] mem [0:1023];
    logic        pre_en = 1'b0;
    logic [9:0]  pre_idx = '0;
    logic [31:0] pre_dat = '0;

    assign mem_rd = mem[mem_a[11:2]];

    always @(posedge clk) begin
        if (mem_we)      mem[mem_a[11:2]] <= mem_wd;
        else if (pre_en) mem[pre_idx] <= pre_dat;
    end

    always #5 clk = ~clk;

    dmem_lsu #(.XLEN(32), .ADDR_SIZE(32)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .req_ready(req_ready), .load_valid(load_valid), .load_data(load_data),
        .err(err), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_pc(mem_pc), .mem_rd(mem_rd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a request seen valid&ready at one negedge must show its
    // response at the next negedge; otherwise nothing may be asserted.
    bit   pending = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        if (!rstn) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_response: got a response with empty scoreboard (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    case (e.kind)
                        K_LOAD: begin
                            chk("load_valid", {31'b0, load_valid}, 32'd1);
                            chk("load_data", load_data, e.d);
                            chk("load_no_err", {30'b0, err, mem_we}, 32'd0);
                        end
                        K_ERR: begin
                            chk("err_pulse", {31'b0, err}, 32'd1);
                            chk("err_no_side", {30'b0, load_valid, mem_we}, 32'd0);
                        end
                        default: begin
                            chk("store_we", {31'b0, mem_we}, 32'd1);
                            chk("store_a", mem_a, e.a);
                            chk("store_wd", mem_wd, e.d);
                            chk("store_pc", mem_pc, e.pc);
                            chk("store_ready_low", {31'b0, req_ready}, 32'd0);
                            chk("store_no_pulse", {30'b0, load_valid, err}, 32'd0);
                        end
                    endcase
                end
            end else begin
                chk("quiet_cycle", {29'b0, load_valid, err, mem_we}, 32'd0);
            end
            pending = req_valid && req_ready;
        end
    end

    task automatic idle();
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        req_pc     = '0;
    endtask

    task automatic preload(input int idx, input logic [31:0] dat);
        pre_en  = 1'b1;
        pre_idx = idx[9:0];
        pre_dat = dat;
        @(posedge clk); #1;
        pre_en  = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 right after acceptance.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] pc, input int kind,
                         input logic [31:0] ed, input logic [31:0] ea, output int waits);
        exp_t x;
        logic rdy;
        bit   accepted;
        x.kind = kind; x.d = ed; x.a = ea; x.pc = pc;
        q.push_back(x);
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wd; req_pc = pc;
        waits = 0;
        accepted = 1'b0;
        for (int k = 0; k < 20 && !accepted; k++) begin
            rdy = req_ready;
            @(posedge clk); #1;
            if (rdy) accepted = 1'b1;
            else     waits++;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no req_ready in 20 cycles expected acceptance (addr %h)", addr);
        end
    endtask

    int w;
    int total_waits;

    initial begin
        idle();
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_load_valid", {31'b0, load_valid}, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // IDLE address path is combinational and word-aligned
        req_addr = 32'h13; req_pc = 32'h44;
        #1;
        chk("idle_mem_a", mem_a, 32'h10);
        chk("idle_mem_pc", mem_pc, 32'h44);
        idle();
        @(posedge clk); #1;

        // SB into 0x11223344 at byte 1
        preload(4, 32'h11223344);
        issue(1'b1, 3'b000, 32'h11, 32'h000000AB, 32'h200, K_STORE, 32'h1122AB44, 32'h10, w);
        idle();
        repeat (2) @(posedge clk); #1;
        chk("sb_mem_word", mem[4], 32'h1122AB44);

        // Load extension table, back-to-back
        preload(4, 32'h80223344);
        issue(1'b0, 3'b000, 32'h13, 32'h0, 32'h204, K_LOAD, 32'hFFFFFF80, 32'h0, w);
        issue(1'b0, 3'b100, 32'h13, 32'h0, 32'h208, K_LOAD, 32'h00000080, 32'h0, w);
        issue(1'b0, 3'b001, 32'h12, 32'h0, 32'h20C, K_LOAD, 32'hFFFF8022, 32'h0, w);
        issue(1'b0, 3'b101, 32'h10, 32'h0, 32'h210, K_LOAD, 32'h00003344, 32'h0, w);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h214, K_LOAD, 32'h80223344, 32'h0, w);
        idle();
        repeat (2) @(posedge clk); #1;

        // Misaligned / illegal requests
        issue(1'b1, 3'b001, 32'h13, 32'h1234, 32'h218, K_ERR, 32'h0, 32'h0, w);
        issue(1'b0, 3'b010, 32'h02, 32'h0, 32'h21C, K_ERR, 32'h0, 32'h0, w);
        issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h220, K_ERR, 32'h0, 32'h0, w);
        idle();
        repeat (2) @(posedge clk); #1;
        chk("err_load_data_kept", load_data, 32'h80223344);
        chk("err_mem_untouched", mem[4], 32'h80223344);

        // SH followed by a held LHU that reads the freshly written word
        preload(8, 32'h0);
        issue(1'b1, 3'b001, 32'h22, 32'h0000BEEF, 32'h300, K_STORE, 32'hBEEF0000, 32'h20, w);
        issue(1'b0, 3'b101, 32'h22, 32'h0, 32'h304, K_LOAD, 32'h0000BEEF, 32'h0, w);
        chk("lhu_held_one_cycle", w, 32'd1);
        idle();
        repeat (2) @(posedge clk); #1;

        // Reset asserted mid-WRITE
        preload(16, 32'h12345678);
        issue(1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 32'h400, K_STORE, 32'hDEADBEEF, 32'h40, w);
        idle();
        @(negedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("rst_mid_write_we", {31'b0, mem_we}, 32'd0);
        @(posedge clk); #1;
        chk("rst_mid_write_mem", mem[16], 32'h12345678);
        rstn = 1'b1;
        #1;
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("post_rst_pulses", {29'b0, load_valid, err, mem_we}, 32'd0);
        chk("post_rst_load_data", load_data, 32'd0);
        chk("post_rst_mem_wd", mem_wd, 32'd0);
        chk("post_rst_mem_a", mem_a, 32'd0);
        chk("post_rst_mem_pc", mem_pc, 32'd0);
        @(posedge clk); #1;

        // Ten back-to-back word loads
        for (int i = 0; i < 10; i++) preload(i, 32'hC0DE0000 + 32'(i) * 32'h111);
        total_waits = 0;
        for (int i = 0; i < 10; i++) begin
            issue(1'b0, 3'b010, 32'(i) * 32'd4, 32'h0, 32'h500 + 32'(i) * 32'd4, K_LOAD,
                  32'hC0DE0000 + 32'(i) * 32'h111, 32'h0, w);
            total_waits += w;
        end
        idle();
        chk("lw_stream_no_stall", total_waits, 32'd0);

        repeat (3) @(posedge clk); #1;
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000 expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
